// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM generator: counter widths and
// the frequency-code to prescaler terminal-count mapping.
package pwm_pkg;

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned FREC_W    = 3;
    localparam int unsigned NUM_CODES = 1 << FREC_W;
    localparam int unsigned PRESC_W   = NUM_CODES - 1;

    typedef logic [FREC_W-1:0] frec_t;

    // Code k divides the clock by 2^k, so the prescaler terminates at 2^k-1.
    function automatic logic [PRESC_W-1:0] term_count(input frec_t code);
        return PRESC_W'((32'd1 << code) - 32'd1);
    endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// Control/status bundle between the frequency selector side and pwm_gen.
interface pwm_gen_if #(
    parameter int unsigned CNT_W = pwm_pkg::CNT_W
);
    import pwm_pkg::*;

    frec_t            frec_sel;
    logic [CNT_W-1:0] duty;
    logic             enable;
    logic             pwm_out;
    logic             period_end;
    frec_t            frec_active;

    modport master (
        output frec_sel, duty, enable,
        input  pwm_out, period_end, frec_active
    );

    modport slave (
        input  frec_sel, duty, enable,
        output pwm_out, period_end, frec_active
    );

endinterface

// File: rtl/pwm_prescaler.sv
// Power-of-two clock divider: tick is high on the last clock of each
// 2^frec_sh-clock group and is combinational from the current count.
module pwm_prescaler #(
    parameter int unsigned PRESC_W = pwm_pkg::PRESC_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  pwm_pkg::frec_t      frec_sh,
    output logic                tick
);
    import pwm_pkg::*;

    logic [PRESC_W-1:0] presc;

    assign tick = (presc == PRESC_W'(term_count(frec_sh)));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator with double-buffered frequency code and duty word; both
// take effect only at period boundaries so upstream changes never glitch.
module pwm_gen #(
    parameter int unsigned CNT_W   = pwm_pkg::CNT_W,
    parameter int unsigned PRESC_W = pwm_pkg::PRESC_W
) (
    input  logic      clock,
    input  logic      reset,
    pwm_gen_if.slave  bus
);
    import pwm_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_sh;
    frec_t            frec_sh;
    logic             tick;
    logic             boundary_c;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clock   (clock),
        .reset   (reset),
        .clear   (!bus.enable),
        .frec_sh (frec_sh),
        .tick    (tick)
    );

    // Last clock of the period: the final tick of the final count.
    assign boundary_c      = bus.enable && tick && (cnt == CNT_MAX);
    assign bus.period_end  = boundary_c;
    assign bus.frec_active = frec_sh;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            duty_sh     <= '0;
            frec_sh     <= '0;
            bus.pwm_out <= 1'b0;
        end else begin
            bus.pwm_out <= bus.enable && (cnt < duty_sh);
            if (!bus.enable) begin
                // Idle: hold counters at zero and keep shadows tracking inputs.
                cnt     <= '0;
                duty_sh <= bus.duty;
                frec_sh <= bus.frec_sel;
            end else if (tick) begin
                cnt <= cnt + CNT_W'(1);
                if (boundary_c) begin
                    duty_sh <= bus.duty;
                    frec_sh <= bus.frec_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: a table of frequency/duty waveforms plus
// hand-written sequences for mid-period changes, disable and reset.
module tb_pwm_gen;
    import pwm_pkg::*;

    localparam int LIMIT = 40000;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    pwm_gen_if #(.CNT_W(CNT_W)) bus ();

    pwm_gen #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0] frec;
        logic [7:0] duty;
        int         exp_high;
        int         exp_len;
        int         exp_first;
    } vec_t;

    vec_t vecs [6];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_pe(input string name);
        int i = 0;
        while (!bus.period_end && i < LIMIT) begin
            step();
            i++;
        end
        check(name, int'(bus.period_end), 1);
    endtask

    // Counts clocks and high clocks from the current sample up to and including
    // the next period_end; optionally changes inputs after chg_at samples.
    task automatic measure(input int chg_at, input logic [2:0] nf, input logic [7:0] nd,
                           output int hi, output int len);
        hi  = 0;
        len = 0;
        for (int i = 0; i < LIMIT; i++) begin
            if (len == chg_at) begin
                bus.frec_sel = nf;
                bus.duty     = nd;
            end
            hi += int'(bus.pwm_out);
            len++;
            if (bus.period_end) break;
            step();
        end
    endtask

    initial begin
        int hi, len;

        vecs[0] = '{3'd0, 8'd64,  64,   256,  1};
        vecs[1] = '{3'd3, 8'd128, 1024, 2048, 1};
        vecs[2] = '{3'd0, 8'd0,   0,    256,  0};
        vecs[3] = '{3'd0, 8'd255, 255,  256,  1};
        vecs[4] = '{3'd1, 8'd10,  20,   512,  1};
        vecs[5] = '{3'd2, 8'd200, 800,  1024, 1};

        // Reset held for three clocks with idle inputs.
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.duty     = 8'd64;
        bus.frec_sel = 3'd0;
        repeat (3) step();
        check("rst_pwm", int'(bus.pwm_out), 0);
        check("rst_pe", int'(bus.period_end), 0);
        check("rst_fa", int'(bus.frec_active), 0);
        reset = 1'b0;
        step();
        check("idle_fa0", int'(bus.frec_active), 0);
        bus.frec_sel = 3'd5;
        step();
        check("idle_fa5", int'(bus.frec_active), 5);
        check("idle_pwm", int'(bus.pwm_out), 0);

        // Steady-state waveforms from the vector table.
        for (int v = 0; v < 6; v++) begin
            bus.enable   = 1'b0;
            bus.frec_sel = vecs[v].frec;
            bus.duty     = vecs[v].duty;
            step();
            step();
            check($sformatf("v%0d_idle_pwm", v), int'(bus.pwm_out), 0);
            check($sformatf("v%0d_idle_fa", v), int'(bus.frec_active), int'(vecs[v].frec));
            bus.enable = 1'b1;
            step();
            check($sformatf("v%0d_first", v), int'(bus.pwm_out), vecs[v].exp_first);
            wait_pe($sformatf("v%0d_pe", v));
            step();
            measure(-1, 3'd0, 8'd0, hi, len);
            check($sformatf("v%0d_high", v), hi, vecs[v].exp_high);
            check($sformatf("v%0d_len", v), len, vecs[v].exp_len);
            check($sformatf("v%0d_fa", v), int'(bus.frec_active), int'(vecs[v].frec));
        end

        // Mid-period change of duty and frequency.
        bus.enable   = 1'b0;
        bus.frec_sel = 3'd0;
        bus.duty     = 8'd64;
        step();
        bus.enable = 1'b1;
        wait_pe("chg_pe");
        step();
        measure(10, 3'd2, 8'd200, hi, len);
        check("chg_cur_high", hi, 64);
        check("chg_cur_len", len, 256);
        check("chg_fa_at_pe", int'(bus.frec_active), 0);
        step();
        check("chg_fa_after", int'(bus.frec_active), 2);
        measure(-1, 3'd0, 8'd0, hi, len);
        check("chg_new_high", hi, 800);
        check("chg_new_len", len, 1024);

        // Disable mid-high, then restart into a fresh period.
        bus.enable   = 1'b0;
        bus.frec_sel = 3'd0;
        bus.duty     = 8'd64;
        step();
        bus.enable = 1'b1;
        wait_pe("dis_pe");
        step();
        repeat (29) step();
        check("dis_pre_pwm", int'(bus.pwm_out), 1);
        bus.enable = 1'b0;
        step();
        check("dis_pwm", int'(bus.pwm_out), 0);
        check("dis_pe_low", int'(bus.period_end), 0);
        bus.enable = 1'b1;
        step();
        check("restart_pwm", int'(bus.pwm_out), 1);
        measure(-1, 3'd0, 8'd0, hi, len);
        check("restart_high", hi, 64);
        check("restart_len", len, 255);

        // Reset while running and high.
        bus.enable   = 1'b0;
        bus.frec_sel = 3'd1;
        bus.duty     = 8'd100;
        step();
        bus.enable = 1'b1;
        wait_pe("rr_pe");
        step();
        repeat (5) step();
        check("rr_pre_pwm", int'(bus.pwm_out), 1);
        check("rr_pre_fa", int'(bus.frec_active), 1);
        reset = 1'b1;
        step();
        check("rr_pwm", int'(bus.pwm_out), 0);
        check("rr_fa", int'(bus.frec_active), 0);
        check("rr_pe", int'(bus.period_end), 0);
        reset      = 1'b0;
        bus.enable = 1'b0;
        step();
        check("rr_idle_fa", int'(bus.frec_active), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
